// File: rtl/sum_accumulator_pkg.sv
// sum_accumulator_pkg
//   Shared definitions for the grouped-sum accumulator: default operand and
//   beat-counter widths, plus the control FSM state encoding.
package sum_accumulator_pkg;

  localparam int DEFAULT_N  = 16;
  localparam int DEFAULT_CW = 8;

  // IDLE : no beat of the current group seen yet
  // ACCUM: at least one beat taken, InLast not yet seen
  // HOLD : a finished group result is being presented
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } accState_t;

endpackage

// File: rtl/sum_accumulator_if.sv
// sum_accumulator_if
//   Operand stream (InValid/InReady/InData/InLast) and result stream
//   (OutValid/OutReady/OutSum/CarryOut/OverFlow/OutCount) of the accumulator.
//   slave  : view used by the accumulator itself
//   master : view used by whatever feeds operands and consumes results
interface sum_accumulator_if
  import sum_accumulator_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int CW = DEFAULT_CW
);

  logic          InValid;
  logic          InReady;
  logic [N-1:0]  InData;
  logic          InLast;
  logic          OutValid;
  logic          OutReady;
  logic [N-1:0]  OutSum;
  logic          CarryOut;
  logic          OverFlow;
  logic [CW-1:0] OutCount;

  modport slave (
    input  InValid, InData, InLast, OutReady,
    output InReady, OutValid, OutSum, CarryOut, OverFlow, OutCount
  );

  modport master (
    output InValid, InData, InLast, OutReady,
    input  InReady, OutValid, OutSum, CarryOut, OverFlow, OutCount
  );

endinterface

// File: rtl/sum_accumulator_add_core.sv
// add_core
//   Purely combinational N-bit adder.
//   a, b     : operands (two's complement or unsigned, same bits)
//   sum      : a + b modulo 2^N
//   carry    : unsigned carry out of bit N-1
//   overflow : signed overflow (both operands' signs differ from the result's)
module add_core
  import sum_accumulator_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         carry,
  output logic         overflow
);

  logic [N:0] wideSum;

  assign wideSum  = {1'b0, a} + {1'b0, b};
  assign sum      = wideSum[N-1:0];
  assign carry    = wideSum[N];
  assign overflow = (a[N-1] ^ wideSum[N-1]) & (b[N-1] ^ wideSum[N-1]);

endmodule

// File: rtl/sum_accumulator.sv
// sum_accumulator
//   Sums groups of operand beats delimited by InLast and presents each group
//   result (sum modulo 2^N, sticky carry, sticky signed overflow, saturating
//   beat count) until the downstream takes it.
//   Clk   : rising-edge clock
//   Reset : synchronous, active-high reset
//   bus   : operand and result streams (slave view)
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int CW = DEFAULT_CW
) (
  input  logic                Clk,
  input  logic                Reset,
  sum_accumulator_if.slave    bus
);

  accState_t     stateReg;
  accState_t     stateNext;

  logic [N-1:0]  accReg;
  logic          carryReg;
  logic          ovfReg;
  logic [CW-1:0] countReg;

  logic          inReady;
  logic          outValid;
  logic          accept;
  logic          continuing;

  logic [N-1:0]  addA;
  logic [N-1:0]  addSum;
  logic          addCarry;
  logic          addOvf;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (accept) stateNext = bus.InLast ? HOLD : ACCUM;
      end
      ACCUM: begin
        if (accept && bus.InLast) stateNext = HOLD;
      end
      HOLD: begin
        // A beat taken while releasing the result opens the next group
        // exactly as if it arrived in IDLE.
        if (accept)            stateNext = bus.InLast ? HOLD : ACCUM;
        else if (bus.OutReady) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    outValid = (stateReg == HOLD);
    // While holding, a new beat may only enter when the result leaves.
    inReady  = (stateReg != HOLD) | bus.OutReady;
  end

  // ---------------------------------------------------------------- datapath
  assign accept     = bus.InValid & inReady;
  // Only ACCUM carries the running total forward; IDLE and HOLD both start
  // a fresh group, so the add is done against zero and yields no flags.
  assign continuing = (stateReg == ACCUM);
  assign addA       = continuing ? accReg : '0;

  add_core #(.N(N)) addCore (
    .a        (addA),
    .b        (bus.InData),
    .sum      (addSum),
    .carry    (addCarry),
    .overflow (addOvf)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      accReg   <= '0;
      carryReg <= 1'b0;
      ovfReg   <= 1'b0;
      countReg <= '0;
    end else if (accept) begin
      accReg   <= addSum;
      carryReg <= (continuing & carryReg) | addCarry;
      ovfReg   <= (continuing & ovfReg) | addOvf;
      if (!continuing) begin
        countReg <= CW'(1);
      end else if (countReg != '1) begin
        countReg <= countReg + CW'(1);
      end
    end else if ((stateReg == HOLD) && bus.OutReady) begin
      accReg   <= '0;
      carryReg <= 1'b0;
      ovfReg   <= 1'b0;
      countReg <= '0;
    end
  end

  assign bus.InReady  = inReady;
  assign bus.OutValid = outValid;
  assign bus.OutSum   = accReg;
  assign bus.CarryOut = carryReg;
  assign bus.OverFlow = ovfReg;
  assign bus.OutCount = countReg;

endmodule
